frame_magnitude_accumulator: RTL and testbench

Consumes the unsigned magnitude stream produced by `absolute_value` (`ivalid`/`idata`) and reduces it to per-frame statistics for the speech front end. For each frame it reports the sum of magnitudes (short-term energy proxy), the peak magnitude, and the sample count. Frames close either after `FRAME_LEN` accepted samples or on an explicit flush. It sits between `absolute_value` and the feature/decision logic.

---
 rtl/frame_magnitude_accumulator.sv | 110 +++++++++++
 tb/tb_frame_magnitude_accumulator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/frame_magnitude_accumulator.sv
// Reduces an unsigned magnitude stream to per-frame sum, peak and sample count.
// A frame closes after FRAME_LEN samples or on flush, and the results are registered.
module frame_magnitude_accumulator #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned CNT_W     = $clog2(FRAME_LEN) + 1,
    parameter int unsigned ACC_W     = DATA_W + $clog2(FRAME_LEN)
) (
    input  logic              iclk,
    input  logic              irstn,
    input  logic              ivalid,
    input  logic [DATA_W-1:0] idata,
    input  logic              iflush,
    output logic              ovalid,
    output logic [ACC_W-1:0]  osum,
    output logic [DATA_W-1:0] opeak,
    output logic [CNT_W-1:0]  ocount
);

    typedef enum logic {
        S_EMPTY   = 1'b0,
        S_FILLING = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [DATA_W-1:0]   r_pk;
    logic [CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]    w_acc_eff;
    logic [DATA_W-1:0]   w_pk_eff;
    logic [CNT_W-1:0]    w_cnt_eff;
    logic                w_close;

    // Effective frame values include a sample accepted on this same edge.
    always_comb begin
        w_acc_eff   = r_acc;
        w_pk_eff    = r_pk;
        w_cnt_eff   = r_cnt;
        w_close     = 1'b0;
        w_state_nxt = r_state;

        if (ivalid) begin
            w_acc_eff = r_acc + ACC_W'(idata);
            w_cnt_eff = r_cnt + CNT_W'(1);
            if (idata > r_pk) begin
                w_pk_eff = idata;
            end
        end

        w_close = (w_cnt_eff == CNT_W'(FRAME_LEN)) ||
                  (iflush && (w_cnt_eff != '0));

        case (r_state)
            S_EMPTY: begin
                if (ivalid && !w_close) begin
                    w_state_nxt = S_FILLING;
                end
            end
            S_FILLING: begin
                if (w_close) begin
                    w_state_nxt = S_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Running statistics clear on close so the next edge can start a new frame.
    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            r_acc <= '0;
            r_pk  <= '0;
            r_cnt <= '0;
        end else if (w_close) begin
            r_acc <= '0;
            r_pk  <= '0;
            r_cnt <= '0;
        end else begin
            r_acc <= w_acc_eff;
            r_pk  <= w_pk_eff;
            r_cnt <= w_cnt_eff;
        end
    end

    // Result registers hold their last frame between pulses.
    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            ovalid <= 1'b0;
            osum   <= '0;
            opeak  <= '0;
            ocount <= '0;
        end else begin
            ovalid <= w_close;
            if (w_close) begin
                osum   <= w_acc_eff;
                opeak  <= w_pk_eff;
                ocount <= w_cnt_eff;
            end
        end
    end

endmodule

// File: tb/tb_frame_magnitude_accumulator.sv
// Bench for frame_magnitude_accumulator: directed cases plus random traffic,
// compared against a queue-based frame model.
module tb_frame_magnitude_accumulator;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN) + 1;
    localparam int unsigned ACC_W     = DATA_W + $clog2(FRAME_LEN);

    logic              iclk;
    logic              irstn;
    logic              ivalid;
    logic [DATA_W-1:0] idata;
    logic              iflush;
    logic              ovalid;
    logic [ACC_W-1:0]  osum;
    logic [DATA_W-1:0] opeak;
    logic [CNT_W-1:0]  ocount;

    int n_vec;
    int n_err;

    // Model state: samples of the open frame and the last emitted results.
    int unsigned frame_q[$];
    logic        exp_valid;
    int unsigned exp_sum;
    int unsigned exp_peak;
    int unsigned exp_count;
    int          pulses;

    frame_magnitude_accumulator #(
        .DATA_W   (DATA_W),
        .FRAME_LEN(FRAME_LEN)
    ) u_dut (
        .iclk  (iclk),
        .irstn (irstn),
        .ivalid(ivalid),
        .idata (idata),
        .iflush(iflush),
        .ovalid(ovalid),
        .osum  (osum),
        .opeak (opeak),
        .ocount(ocount)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".ovalid"}, 32'(ovalid), 32'(exp_valid));
        check_val({tag, ".osum"},   32'(osum),   exp_sum);
        check_val({tag, ".opeak"},  32'(opeak),  exp_peak);
        check_val({tag, ".ocount"}, 32'(ocount), exp_count);
    endtask

    // Frame statistics computed directly from the collected samples.
    task automatic model_edge(input logic v, input int unsigned d, input logic f);
        int unsigned s;
        int unsigned p;
        if (v) frame_q.push_back(d);
        exp_valid = 1'b0;
        if (frame_q.size() == FRAME_LEN || (f && frame_q.size() > 0)) begin
            s = 0;
            p = 0;
            foreach (frame_q[i]) begin
                s += frame_q[i];
                if (frame_q[i] > p) p = frame_q[i];
            end
            exp_valid = 1'b1;
            exp_sum   = s;
            exp_peak  = p;
            exp_count = frame_q.size();
            frame_q.delete();
            pulses++;
        end
    endtask

    task automatic step(input string tag, input logic v, input int unsigned d, input logic f);
        @(negedge iclk);
        ivalid = v;
        idata  = DATA_W'(d);
        iflush = f;
        @(posedge iclk);
        model_edge(v, d, f);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge iclk);
        ivalid = 1'b0;
        iflush = 1'b0;
        idata  = '0;
        irstn  = 1'b0;
        frame_q.delete();
        exp_valid = 1'b0;
        exp_sum   = 0;
        exp_peak  = 0;
        exp_count = 0;
        #2;
        check_outputs("reset");
        @(negedge iclk);
        irstn = 1'b1;
    endtask

    initial begin
        int unsigned t2[4];
        n_vec  = 0;
        n_err  = 0;
        pulses = 0;
        irstn  = 1'b1;
        ivalid = 1'b0;
        idata  = '0;
        iflush = 1'b0;
        t2[0] = 3; t2[1] = 1; t2[2] = 5; t2[3] = 2;

        // 1: reset, idle, flush while empty
        do_reset();
        idle("idle", 5);
        step("flush_empty", 1'b0, 0, 1'b1);
        idle("idle2", 1);

        // 2: back-to-back frame
        for (int i = 0; i < 4; i++) step("b2b", 1'b1, t2[i], 1'b0);
        idle("b2b_after", 1);
        check_val("b2b_pulses", 32'(pulses), 32'd1);

        // 3: same samples with gaps; outputs hold afterwards
        for (int i = 0; i < 4; i++) begin
            step("gap", 1'b1, t2[i], 1'b0);
            idle("gap_idle", int'($urandom_range(1, 3)));
        end
        idle("hold", 4);
        check_val("gap_pulses", 32'(pulses), 32'd2);

        // 4: all-ones frame
        for (int i = 0; i < 4; i++) step("ones", 1'b1, 32'hFFFF, 1'b0);
        idle("ones_after", 1);

        // 5: flush cases
        step("fl_a", 1'b1, 7, 1'b0);
        step("fl_a", 1'b1, 9, 1'b0);
        step("fl_a", 1'b0, 0, 1'b1);
        idle("fl_a_after", 1);
        step("fl_b", 1'b1, 7, 1'b0);
        step("fl_b", 1'b1, 9, 1'b0);
        step("fl_b", 1'b1, 4, 1'b1);
        idle("fl_b_after", 1);
        step("fl_c", 1'b1, 1, 1'b0);
        step("fl_c", 1'b1, 2, 1'b0);
        step("fl_c", 1'b1, 3, 1'b0);
        step("fl_c", 1'b1, 4, 1'b1);
        step("fl_c_single", 1'b1, 6, 1'b1);
        idle("fl_c_after", 2);

        // 6: continuous 1..8, then reset mid-frame
        for (int i = 1; i <= 8; i++) step("cont", 1'b1, i, 1'b0);
        step("cont_mid", 1'b1, 9, 1'b0);
        step("cont_mid", 1'b1, 9, 1'b0);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 4; i++) step("post_rst", 1'b1, 1, 1'b0);
        idle("post_rst_after", 2);
        check_val("post_rst_pulses", 32'(pulses), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic        v;
            logic        f;
            int unsigned d;
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 4) == 0) ? 32'hFFFF : $urandom_range(0, 32'hFFFF);
            step("rand", v, d, f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
